// File: rtl/pll_clken_gen.sv
// pll_clken_gen: lock-qualified multi-channel NCO clock-enable generator on refclk.
// Optional per-channel phase offsets when PLL_CLKEN_PHASE_OFFSET_EN is defined (adds wr_sel).
module pll_clken_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 32,
  parameter int LOCK_CNT = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC = {32'd412316860, 32'd206158430},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ACC_W-1:0]  wr_data,
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
  input  logic              wr_sel,
`endif
  input  logic              resync,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_sq,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CNT);

  localparam logic [0:0] ST_WAIT_LOCK = 1'b0;
  localparam logic [0:0] ST_RUN       = 1'b1;

  logic [0:0]       state;
  logic             sync_meta;
  logic             sync_locked;
  logic [CNT_W-1:0] lock_cnt;

  logic [ACC_W-1:0] acc        [NUM_CH];
  logic [ACC_W-1:0] inc_shadow [NUM_CH];
  logic [ACC_W-1:0] inc_active [NUM_CH];
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
  logic [ACC_W-1:0] phase_ofs  [NUM_CH];
`endif

  logic [ACC_W:0]   sum         [NUM_CH];
  logic [ACC_W-1:0] shadow_next [NUM_CH];
  logic [ACC_W-1:0] start_val   [NUM_CH];
  logic [NUM_CH-1:0] inc_hit;
  logic [NUM_CH-1:0] ofs_hit;
  logic             wr_ch_ok;
  logic             inc_sel;

  assign wr_ch_ok = (int'(wr_ch) < NUM_CH);
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
  assign inc_sel = ~wr_sel;
`else
  assign inc_sel = 1'b1;
`endif

  always_comb begin
    inc_hit = '0;
    ofs_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]         = {1'b0, acc[i]} + {1'b0, inc_active[i]};
      inc_hit[i]     = wr_en && wr_ch_ok && inc_sel && (wr_ch == CH_W'(i));
      ofs_hit[i]     = wr_en && wr_ch_ok && !inc_sel && (wr_ch == CH_W'(i));
      // A write landing on a carry must reach active directly, not via the old shadow.
      shadow_next[i] = inc_hit[i] ? wr_data : inc_shadow[i];
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
      start_val[i]   = phase_ofs[i];
`else
      start_val[i]   = '0;
`endif
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      sync_locked <= 1'b0;
      lock_cnt    <= '0;
      state       <= ST_WAIT_LOCK;
      locked      <= 1'b0;
      ch_en       <= '0;
      ch_sq       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]        <= '0;
        inc_shadow[i] <= DEF_INC[i*ACC_W +: ACC_W];
        inc_active[i] <= DEF_INC[i*ACC_W +: ACC_W];
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
        phase_ofs[i]  <= '0;
`endif
      end
    end else begin
      sync_meta   <= pll_locked;
      sync_locked <= sync_meta;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (inc_hit[i]) inc_shadow[i] <= wr_data;
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
        if (ofs_hit[i]) phase_ofs[i] <= wr_data;
`endif
      end

      case (state)
        ST_WAIT_LOCK: begin
          ch_en <= '0;
          ch_sq <= '0;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            inc_active[i] <= inc_shadow[i];
            acc[i]        <= '0;
          end
          if (!sync_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_W'(LOCK_CNT - 1)) begin
            state    <= ST_RUN;
            locked   <= 1'b1;
            lock_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc[i]   <= start_val[i];
              ch_sq[i] <= start_val[i][ACC_W-1];
            end
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: begin
          if (!sync_locked) begin
            state  <= ST_WAIT_LOCK;
            locked <= 1'b0;
            ch_en  <= '0;
            ch_sq  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc[i]        <= '0;
              inc_active[i] <= inc_shadow[i];
            end
          end else if (resync) begin
            ch_en <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc[i]        <= start_val[i];
              ch_sq[i]      <= start_val[i][ACC_W-1];
              inc_active[i] <= inc_shadow[i];
            end
          end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              acc[i]   <= sum[i][ACC_W-1:0];
              ch_en[i] <= sum[i][ACC_W];
              ch_sq[i] <= sum[i][ACC_W-1];
              // A zero increment never carries, so it must also accept updates.
              if (sum[i][ACC_W] || (inc_active[i] == '0))
                inc_active[i] <= shadow_next[i];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed self-checking bench for pll_clken_gen: 3 channels, 8-bit NCO, LOCK_CNT=16.
module tb_pll_clken_gen;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic       resync = 1'b0;
  logic [2:0] ch_en;
  logic [2:0] ch_sq;
  logic       locked;
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
  logic       wr_sel = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  pll_clken_gen #(
    .NUM_CH  (3),
    .ACC_W   (8),
    .LOCK_CNT(16),
    .DEF_INC ({8'd16, 8'd128, 8'd64})
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
`ifdef PLL_CLKEN_PHASE_OFFSET_EN
    .wr_sel    (wr_sel),
`endif
    .resync    (resync),
    .ch_en     (ch_en),
    .ch_sq     (ch_sq),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] d);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_strobe(input int ch, output int at);
    at = -1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (ch_en[ch]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_locked(input int resync_at, output int at, output int en_seen);
    at = -1;
    en_seen = 0;
    for (int k = 0; k < 60; k++) begin
      resync = (cyc == resync_at);
      tick();
      if (ch_en != 3'b000) en_seen++;
      if (locked) begin
        at = cyc;
        break;
      end
    end
    resync = 1'b0;
  endtask

  initial begin
    int at, seen;
    int cnt0, cnt1, cnt2, gap0, gap1, gap2, last0, last1, last2, sq_bad;
    int hold_en, hold_sq;

    tick();
    tick();
    check("reset_locked", locked, 0);
    check("reset_ch_en", ch_en, 0);
    check("reset_ch_sq", ch_sq, 0);
    rst = 1'b0;
    cyc = 0;

    // Lock qualification: pll_locked rises after cycle 10, locked expected at 28.
    for (int k = 0; k < 10; k++) tick();
    pll_locked = 1'b1;
    wait_locked(-1, at, seen);
    check("lock_latency", at, 28);
    check("lock_no_strobe", seen, 0);

    // Rate: 256 cycles with inc 64/128/16.
    cnt0 = 0; cnt1 = 0; cnt2 = 0; gap0 = 0; gap1 = 0; gap2 = 0; sq_bad = 0;
    last0 = 28; last1 = 28; last2 = 28;
    for (int j = 1; j <= 256; j++) begin
      tick();
      if (ch_en[0]) begin cnt0++; if (cyc - last0 != 4) gap0++; last0 = cyc; end
      if (ch_en[1]) begin cnt1++; if (cyc - last1 != 2) gap1++; last1 = cyc; end
      if (ch_en[2]) begin cnt2++; if (cyc - last2 != 16) gap2++; last2 = cyc; end
      if (ch_sq[0] != ((j % 4) == 2 || (j % 4) == 3)) sq_bad++;
    end
    check("rate_cnt0", cnt0, 64);
    check("rate_cnt1", cnt1, 128);
    check("rate_cnt2", cnt2, 16);
    check("rate_gap0", gap0, 0);
    check("rate_gap1", gap1, 0);
    check("rate_gap2", gap2, 0);
    check("rate_sq0", sq_bad, 0);

    // Glitch-free update: current 4-cycle period completes, then 8-cycle spacing.
    tick();
    tick();
    do_write(2'd0, 8'd32);
    wait_strobe(0, at);
    check("upd_first", at, 288);
    wait_strobe(0, at);
    check("upd_second", at, 296);
    wait_strobe(0, at);
    check("upd_third", at, 304);
    for (int k = 0; k < 7; k++) tick();
    do_write(2'd0, 8'd64);
    check("collide_strobe", ch_en[0], 1);
    wait_strobe(0, at);
    check("collide_next", at, 316);

    // Freeze: inc 240 leaves acc=224 after carry; a colliding write of 0 freezes it.
    do_write(2'd0, 8'd240);
    tick();
    tick();
    tick();
    check("pre_freeze_carry", ch_en[0], 1);
    tick();
    do_write(2'd0, 8'd0);
    check("freeze_last_carry", ch_en[0], 1);
    check("freeze_sq_high", ch_sq[0], 1);
    hold_en = 0; hold_sq = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ch_en[0]) hold_en++;
      if (!ch_sq[0]) hold_sq++;
    end
    check("freeze_en", hold_en, 0);
    check("freeze_sq", hold_sq, 0);
    do_write(2'd0, 8'd32);
    check("unfreeze_no_strobe", ch_en[0], 0);
    tick();
    check("unfreeze_strobe", ch_en[0], 1);

    // Out-of-range channel write is ignored.
    do_write(2'd3, 8'd0);
    wait_strobe(0, at);
    check("bad_ch_ignored", at, 352);

    // Resync at an edge where ch1 would carry.
    do_write(2'd0, 8'd64);
    tick();
    tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("resync_en_zero", ch_en, 0);
    tick();
    check("resync_c357", ch_en, 3'b000);
    tick();
    check("resync_c358", ch_en, 3'b010);
    tick();
    check("resync_c359", ch_en, 3'b000);
    tick();
    check("resync_c360", ch_en, 3'b011);

    // Unlock: one-cycle drop; locked falls 3 cycles later, full requalification.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("unlock_still_locked", locked, 1);
    tick();
    check("unlock_locked", locked, 0);
    check("unlock_ch_en", ch_en, 0);
    check("unlock_ch_sq", ch_sq, 0);
    wait_locked(369, at, seen);
    check("relock_latency", at, 379);
    check("relock_no_strobe", seen, 0);

    // Reset mid-RUN discards the pending shadow write.
    do_write(2'd0, 8'd32);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_locked", locked, 0);
    check("midrst_ch_en", ch_en, 0);
    check("midrst_ch_sq", ch_sq, 0);
    rst = 1'b0;
    wait_locked(-1, at, seen);
    check("midrst_relock", at, 400);
    wait_strobe(1, at);
    check("midrst_ch1", at, 402);
    wait_strobe(0, at);
    check("midrst_def_inc", at, 404);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
